param_alu_pipe: RTL and testbench
=================================

PARAM_ALU_PIPE -- requirements
Module: param_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 Parameter ACC_EN, default 1, 1 = accumulator operand path present, 0 = acc_sel ignored and acc held at 0.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  command valid.
REQ-006 in_ready  output  1  block accepts command this cycle.
REQ-007 op  input  4  opcode.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 acc_sel  input  1  use accumulator instead of a as operand A.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 y  output  WIDTH  result, low half for MUL.
REQ-014 y_hi  output  WIDTH  MUL high half, 0 for all other ops.
REQ-015 flags  output  4  {C,V,N,Z} of the result.

Function
REQ-016 Command accepted (handshake) when in_valid & in_ready high on a rising edge; a, b, op, acc_sel are captured then and never resampled.
REQ-017 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHR A by 1 (logical), 7 SHL A by 1, 8 MUL (unsigned, 2*WIDTH result), 9 PASS B, 10..15 illegal.
REQ-018 FSM states IDLE, EXEC, MUL, DONE; IDLE->EXEC on accept of non-MUL op, IDLE->MUL on accept of MUL, EXEC->DONE after 1 cycle, MUL->DONE after WIDTH cycles, DONE->IDLE on out_ready with no new accept, DONE->EXEC/MUL on out_ready with simultaneous accept.
REQ-019 in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-020 Latency: non-MUL result has out_valid high 2 cycles after accept edge; MUL has out_valid high WIDTH+1 cycles after accept edge.
REQ-021 MUL is an iterative shift-add, one partial-product bit per cycle; no combinational WIDTHxWIDTH multiplier.
REQ-022 out_valid high only in DONE; y, y_hi, flags stable while out_valid high and out_ready low.
REQ-023 Flags: Z = (y==0 and y_hi==0); N = y[WIDTH-1]; C = carry-out for ADD, borrow (a<b) for SUB, bit shifted out for SHR/SHL, (y_hi!=0) for MUL, 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-024 Arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-025 Illegal opcode: y=0, y_hi=0, flags={C=1,V=1,N=0,Z=0} as error marker, same latency as non-MUL.
REQ-026 Accumulator acc (WIDTH bits) loads y when the DONE->exit handshake (out_valid & out_ready) occurs, illegal ops excluded; acc_sel=1 substitutes acc for a.
REQ-027 Back-to-back: with out_ready held high and in_valid held high, one non-MUL result per 2 cycles.

Reset
REQ-028 rst high forces state IDLE, out_valid=0, y=0, y_hi=0, flags=0, acc=0, in_ready=1 asynchronously, mid-MUL included; the aborted command produces no result.
REQ-029 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro PARAM_ALU_MUL_EN defined: MUL opcode and MUL state implemented per REQ-018..021.
REQ-031 Macro PARAM_ALU_MUL_EN undefined: MUL state and multiplier logic absent; opcode 8 treated as illegal per REQ-025; y_hi constant 0.

Verification
REQ-032 WIDTH=8, ADD a=0xFF b=0x01 -> y=0x00, flags C=1 V=0 N=0 Z=1, out_valid 2 cycles after accept.
REQ-033 SUB a=0x80 b=0x01 -> y=0x7F, V=1, C=0; SUB a=0x01 b=0x02 -> y=0xFF, C=1, N=1.
REQ-034 MUL (macro defined) a=0xFF b=0xFF -> y=0x01, y_hi=0xFE, C=1, out_valid exactly 9 cycles after accept; macro undefined -> y=0, flags C=1 V=1.
REQ-035 Backpressure: out_ready low 5 cycles after result -> out_valid, y, flags unchanged, in_ready low; out_ready+in_valid same cycle -> next command accepted, no bubble lost.
REQ-036 Accumulator: ADD a=3 b=4 consumed, then acc_sel=1 ADD b=10 -> y=0x11.
REQ-037 rst pulsed in cycle 4 of MUL -> out_valid never rises for that command, all outputs 0, acc=0, in_ready=1.

Source files
------------

// File: rtl/param_alu_pipe.sv
// param_alu_pipe: handshaked ALU with a four-state control FSM, an optional accumulator operand
// and an iterative shift-add multiplier.
// Define PARAM_ALU_MUL_EN to build the multiplier (opcode 8); without it opcode 8 is illegal
// and y_hi is constant zero.
module param_alu_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpNot  = 4'd5;
    localparam logic [3:0] OpShr  = 4'd6;
    localparam logic [3:0] OpShl  = 4'd7;
    localparam logic [3:0] OpPass = 4'd9;

    // {C,V,N,Z} marker for an illegal opcode
    localparam logic [3:0] FlagsErr = 4'b1100;

`ifdef PARAM_ALU_MUL_EN
    localparam logic [3:0] OpMul   = 4'd8;
    localparam logic [5:0] CntLast = 6'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_t;
`else
    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;
`endif

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opr_a;
    logic [WIDTH-1:0] opr_b;
    logic [WIDTH-1:0] acc;
    logic             err_q;

    logic             accept;
    logic             take;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_sel;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    assign in_ready = (state == StIdle) || ((state == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    // A command accepted in the same cycle the previous result is consumed sees the updated acc.
    assign acc_next = (take && !err_q && (ACC_EN != 0)) ? y : acc;
    assign a_sel    = ((ACC_EN != 0) && acc_sel) ? acc_next : a;

`ifdef PARAM_ALU_MUL_EN
    logic [WIDTH-1:0] mul_hi;
    logic [5:0]       mul_cnt;
    logic [WIDTH:0]   mul_add;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH-1:0] y_hi_q;

    // One shift-add step: opr_b doubles as the low half / remaining multiplier bits.
    assign mul_add  = {1'b0, mul_hi} + (opr_b[0] ? {1'b0, opr_a} : {(WIDTH + 1){1'b0}});
    assign mul_hi_n = mul_add[WIDTH:1];
    assign mul_lo_n = {mul_add[0], opr_b[WIDTH-1:1]};
    assign y_hi     = y_hi_q;
`else
    assign y_hi = '0;
`endif

    // Single-cycle ALU operating on the captured operands
    always_comb begin
        sum     = {1'b0, opr_a} + {1'b0, opr_b};
        diff    = {1'b0, opr_a} - {1'b0, opr_b};
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_y = sum[MSB:0];
                alu_c = sum[WIDTH];
                alu_v = (opr_a[MSB] == opr_b[MSB]) && (sum[MSB] != opr_a[MSB]);
            end
            OpSub: begin
                alu_y = diff[MSB:0];
                alu_c = diff[WIDTH];
                alu_v = (opr_a[MSB] != opr_b[MSB]) && (diff[MSB] != opr_a[MSB]);
            end
            OpAnd:  alu_y = opr_a & opr_b;
            OpOr:   alu_y = opr_a | opr_b;
            OpXor:  alu_y = opr_a ^ opr_b;
            OpNot:  alu_y = ~opr_a;
            OpShr: begin
                alu_y = opr_a >> 1;
                alu_c = opr_a[0];
            end
            OpShl: begin
                alu_y = opr_a << 1;
                alu_c = opr_a[MSB];
            end
            OpPass: alu_y = opr_b;
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM with registered result, flags and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
            acc       <= '0;
            err_q     <= 1'b0;
            op_q      <= '0;
            opr_a     <= '0;
            opr_b     <= '0;
`ifdef PARAM_ALU_MUL_EN
            mul_hi    <= '0;
            mul_cnt   <= '0;
            y_hi_q    <= '0;
`endif
        end else begin
            case (state)
                StExec: begin
                    y         <= alu_y;
                    flags     <= alu_err ? FlagsErr
                                         : {alu_c, alu_v, alu_y[MSB], (alu_y == '0)};
                    err_q     <= alu_err;
                    out_valid <= 1'b1;
                    state     <= StDone;
`ifdef PARAM_ALU_MUL_EN
                    y_hi_q    <= '0;
`endif
                end
`ifdef PARAM_ALU_MUL_EN
                StMul: begin
                    mul_hi  <= mul_hi_n;
                    opr_b   <= mul_lo_n;
                    mul_cnt <= mul_cnt + 6'd1;
                    if (mul_cnt == CntLast) begin
                        y         <= mul_lo_n;
                        y_hi_q    <= mul_hi_n;
                        flags     <= {(mul_hi_n != '0), 1'b0, mul_lo_n[MSB],
                                      (mul_hi_n == '0) && (mul_lo_n == '0)};
                        err_q     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                        if ((ACC_EN != 0) && !err_q) begin
                            acc <= y;
                        end
                    end
                end
                default: ;
            endcase

            // Capture overrides the DONE->IDLE exit when a new command arrives the same cycle
            if (accept) begin
                op_q  <= op;
                opr_a <= a_sel;
                opr_b <= b;
`ifdef PARAM_ALU_MUL_EN
                mul_hi  <= '0;
                mul_cnt <= '0;
                state   <= (op == OpMul) ? StMul : StExec;
`else
                state   <= StExec;
`endif
            end
        end
    end

endmodule

// File: tb/tb_param_alu_pipe.sv
// Directed self-checking bench for param_alu_pipe (WIDTH=8, ACC_EN=1).
// Expectations follow the PARAM_ALU_MUL_EN setting of the build.
module tb_param_alu_pipe;

    localparam int W = 8;

`ifdef PARAM_ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic [3:0]   flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_alu_pipe #(
        .WIDTH  (W),
        .ACC_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_sel   (acc_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; return 1 time unit after the accepting rising edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic sel);
        int k;
        @(negedge clk);
        op = o; a = va; b = vb; acc_sel = sel; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs so any resampling after accept shows up
        in_valid = 1'b0; op = 4'hE; a = ~va; b = ~vb; acc_sel = ~sel;
    endtask

    // Count falling edges after the accept edge until out_valid is seen high.
    task automatic wait_result(input string tag, input int exp_lat);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 40);
        chk(tag, 32'(cnt), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] ey, input logic [W-1:0] eyh,
                             input logic [3:0] ef);
        chk({tag, "_y"}, 32'(y), 32'(ey));
        chk({tag, "_yhi"}, 32'(y_hi), 32'(eyh));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic sel, input int lat,
                       input logic [W-1:0] ey, input logic [W-1:0] eyh, input logic [3:0] ef);
        send(o, va, vb, sel);
        wait_result({tag, "_lat"}, lat);
        check_out(tag, ey, eyh, ef);
        consume(tag);
    endtask

    initial begin
        logic [W-1:0] vals [3];
        int           seen;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = '0; b = '0; acc_sel = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Asynchronous reset: checked before any clock edge
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_out("rst", 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // flags are {C,V,N,Z}
        run("add_ff_01",  4'd0, 8'hFF, 8'h01, 1'b0, 2, 8'h00, 8'h00, 4'b1001);
        run("sub_80_01",  4'd1, 8'h80, 8'h01, 1'b0, 2, 8'h7F, 8'h00, 4'b0100);
        run("sub_01_02",  4'd1, 8'h01, 8'h02, 1'b0, 2, 8'hFF, 8'h00, 4'b1010);
        run("add_7f_01",  4'd0, 8'h7F, 8'h01, 1'b0, 2, 8'h80, 8'h00, 4'b0110);
        run("and",        4'd2, 8'hF0, 8'h3C, 1'b0, 2, 8'h30, 8'h00, 4'b0000);
        run("or",         4'd3, 8'hF0, 8'h0C, 1'b0, 2, 8'hFC, 8'h00, 4'b0010);
        run("xor",        4'd4, 8'hFF, 8'hFF, 1'b0, 2, 8'h00, 8'h00, 4'b0001);
        run("not",        4'd5, 8'h0F, 8'h99, 1'b0, 2, 8'hF0, 8'h00, 4'b0010);
        run("shr",        4'd6, 8'h81, 8'h00, 1'b0, 2, 8'h40, 8'h00, 4'b1000);
        run("shl",        4'd7, 8'h81, 8'h00, 1'b0, 2, 8'h02, 8'h00, 4'b1000);
        run("pass",       4'd9, 8'hAA, 8'h55, 1'b0, 2, 8'h55, 8'h00, 4'b0000);
        run("illegal_12", 4'd12, 8'h12, 8'h34, 1'b0, 2, 8'h00, 8'h00, 4'b1100);

        // Multiply: FF*FF=FE01, 0D*0B=008F, 10*10=0100
        run("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 1'b0, MulEn ? 9 : 2,
            MulEn ? 8'h01 : 8'h00, MulEn ? 8'hFE : 8'h00, MulEn ? 4'b1000 : 4'b1100);
        run("mul_0d_0b", 4'd8, 8'h0D, 8'h0B, 1'b0, MulEn ? 9 : 2,
            MulEn ? 8'h8F : 8'h00, 8'h00, MulEn ? 4'b0010 : 4'b1100);
        run("mul_10_10", 4'd8, 8'h10, 8'h10, 1'b0, MulEn ? 9 : 2,
            8'h00, MulEn ? 8'h01 : 8'h00, MulEn ? 4'b1000 : 4'b1100);

        // Backpressure: result held for 5 cycles, then consume and accept in the same cycle
        send(4'd0, 8'h20, 8'h13, 1'b0);
        wait_result("bp_lat", 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_y", 32'(y), 32'h33);
            chk("bp_flags", 32'(flags), 32'h0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        op = 4'd1; a = 8'h05; b = 8'h03; acc_sel = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_overlap_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; a = 8'hFF; b = 8'hFF;
        wait_result("bp_next_lat", 2);
        check_out("bp_next", 8'h02, 8'h00, 4'b0000);
        consume("bp_next");

        // Accumulator operand: 3+4 consumed, then acc+10; a is ignored when acc_sel=1
        run("acc_load", 4'd0, 8'h03, 8'h04, 1'b0, 2, 8'h07, 8'h00, 4'b0000);
        run("acc_use",  4'd0, 8'hAA, 8'h0A, 1'b1, 2, 8'h11, 8'h00, 4'b0000);
        run("acc_ill",  4'd15, 8'h00, 8'h00, 1'b0, 2, 8'h00, 8'h00, 4'b1100);
        run("acc_keep", 4'd0, 8'hAA, 8'h00, 1'b1, 2, 8'h11, 8'h00, 4'b0000);

        // Back-to-back PASS with in_valid and out_ready held high: one result per 2 cycles
        @(negedge clk);
        op = 4'd9; a = 8'h00; b = vals[0]; acc_sel = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_gap", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_y", 32'(y), 32'(vals[i]));
            if (i < 2) b = vals[i + 1];
            else in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b_end_valid", 32'(out_valid), 32'd0);
        chk("b2b_end_ready", 32'(in_ready), 32'd1);

        // Reset while a command is in flight (mid-multiply when the multiplier is built)
`ifdef PARAM_ALU_MUL_EN
        send(4'd8, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
`else
        send(4'd0, 8'h01, 8'h01, 1'b0);
`endif
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        check_out("midrst", 8'h00, 8'h00, 4'b0000);
        @(posedge clk);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        // Release reset and offer a command immediately: acc must read back as zero
        op = 4'd0; a = 8'h77; b = 8'h00; acc_sel = 1'b1; in_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; acc_sel = 1'b0;
        wait_result("post_rst_lat", 2);
        check_out("post_rst_acc", 8'h00, 8'h00, 4'b0001);
        consume("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
